// File: rtl/enemy_render_ctrl.sv
// rtl/enemy_render_ctrl.sv - enemy sprite erase/draw render controller
//
// Runs one render cycle per enable: it requests a position update from the
// enemy datapath, then erases the previously drawn sprite and draws the
// new one as a SIZE x SIZE square, one pixel per clock, row-major.
//
// Parameters:
//   SIZE       sprite edge length in pixels (1..8)
//   BG_COLOUR  colour written when erasing the old sprite
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                start a render cycle (sampled in IDLE only)
//   doneUpdate            datapath completion pulse (honoured in REQ only)
//   enemy_x/y/colour      datapath sprite position and colour
//   UpdateEnemy           update request to the datapath (high in REQ)
//   plot                  pixel write strobe (low for off-screen pixels)
//   vga_x/vga_y/colour    registered pixel coordinate and colour
//   frame_done            one-cycle pulse at the end of a render cycle
//
// Build macro:
//   ENEMY_RENDER_ERASE_EN  when defined, the old sprite is erased before
//                          each draw; when undefined there is no ERASE state.

module enemy_render_ctrl #(
    parameter int         SIZE      = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       doneUpdate,
    input  logic [7:0] enemy_x,
    input  logic [6:0] enemy_y,
    input  logic [2:0] enemy_colour,
    output logic       UpdateEnemy,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       frame_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] ERASE = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    logic [2:0] state, state_n;
    logic [2:0] px, px_n, py, py_n;
    logic [7:0] old_x, old_x_n, new_x, new_x_n;
    logic [6:0] old_y, old_y_n, new_y, new_y_n;
    logic [2:0] new_col, new_col_n;
    logic       first_frame, first_frame_n;
    logic       upd_n, plot_n, fd_n;
    logic [7:0] x_n;
    logic [6:0] y_n;
    logic [2:0] col_n;

    // Pixel selected for the coming cycle: base + offset, and its colour.
    logic       scan;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] off_x, off_y, scan_col;

    logic       last_pix;
    logic [2:0] adv_px, adv_py;

    assign last_pix = (px == LAST) && (py == LAST);

    // Row-major step: x offset fastest, wrap into the next row.
    always_comb begin
        if (px == LAST) begin
            adv_px = 3'd0;
            adv_py = py + 3'd1;
        end else begin
            adv_px = px + 3'd1;
            adv_py = py;
        end
    end

    always_comb begin
        state_n       = state;
        px_n          = px;
        py_n          = py;
        old_x_n       = old_x;
        old_y_n       = old_y;
        new_x_n       = new_x;
        new_y_n       = new_y;
        new_col_n     = new_col;
        first_frame_n = first_frame;
        upd_n         = 1'b0;
        fd_n          = 1'b0;
        scan          = 1'b0;
        base_x        = old_x;
        base_y        = old_y;
        off_x         = 3'd0;
        off_y         = 3'd0;
        scan_col      = BG_COLOUR;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = REQ;
                    upd_n   = 1'b1;
                end
            end

            REQ: begin
                if (!doneUpdate) begin
                    upd_n = 1'b1;
                end else begin
                    new_x_n   = enemy_x;
                    new_y_n   = enemy_y;
                    new_col_n = enemy_colour;
                    px_n      = 3'd0;
                    py_n      = 3'd0;
                    scan      = 1'b1;
`ifdef ENEMY_RENDER_ERASE_EN
                    if (!first_frame) begin
                        state_n = ERASE;
                    end else
`endif
                    begin
                        // New position is latched on this same edge, so the
                        // first draw pixel comes straight from the inputs.
                        state_n  = DRAW;
                        base_x   = enemy_x;
                        base_y   = enemy_y;
                        scan_col = enemy_colour;
                    end
                end
            end

`ifdef ENEMY_RENDER_ERASE_EN
            ERASE: begin
                scan = 1'b1;
                if (last_pix) begin
                    state_n  = DRAW;
                    px_n     = 3'd0;
                    py_n     = 3'd0;
                    base_x   = new_x;
                    base_y   = new_y;
                    scan_col = new_col;
                end else begin
                    px_n  = adv_px;
                    py_n  = adv_py;
                    off_x = adv_px;
                    off_y = adv_py;
                end
            end
`endif

            DRAW: begin
                if (last_pix) begin
                    state_n = DONE;
                    px_n    = 3'd0;
                    py_n    = 3'd0;
                    fd_n    = 1'b1;
                end else begin
                    scan     = 1'b1;
                    px_n     = adv_px;
                    py_n     = adv_py;
                    base_x   = new_x;
                    base_y   = new_y;
                    off_x    = adv_px;
                    off_y    = adv_py;
                    scan_col = new_col;
                end
            end

            DONE: begin
                old_x_n       = new_x;
                old_y_n       = new_y;
                first_frame_n = 1'b0;
                state_n       = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // Coordinates wrap by truncation; wrapped or out-of-range pixels still
    // take their cycle but are not plotted.
    always_comb begin
        x_n    = vga_x;
        y_n    = vga_y;
        col_n  = vga_colour;
        plot_n = 1'b0;
        if (scan) begin
            x_n    = base_x + {5'd0, off_x};
            y_n    = base_y + {4'd0, off_y};
            col_n  = scan_col;
            plot_n = (x_n <= 8'd159) && (y_n <= 7'd119);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            px          <= 3'd0;
            py          <= 3'd0;
            old_x       <= 8'd0;
            old_y       <= 7'd0;
            new_x       <= 8'd0;
            new_y       <= 7'd0;
            new_col     <= 3'd0;
            first_frame <= 1'b1;
            UpdateEnemy <= 1'b0;
            plot        <= 1'b0;
            frame_done  <= 1'b0;
            vga_x       <= 8'd0;
            vga_y       <= 7'd0;
            vga_colour  <= 3'd0;
        end else begin
            state       <= state_n;
            px          <= px_n;
            py          <= py_n;
            old_x       <= old_x_n;
            old_y       <= old_y_n;
            new_x       <= new_x_n;
            new_y       <= new_y_n;
            new_col     <= new_col_n;
            first_frame <= first_frame_n;
            UpdateEnemy <= upd_n;
            plot        <= plot_n;
            frame_done  <= fd_n;
            vga_x       <= x_n;
            vga_y       <= y_n;
            vga_colour  <= col_n;
        end
    end

endmodule

// File: doc/enemy_render_ctrl.md
ENEMY_RENDER_CTRL -- requirements
Module: enemy_render_ctrl

Interface
REQ-001 SIZE, default 4, edge length in pixels of the square enemy sprite (1..8).
REQ-002 BG_COLOUR, default 3'b000, colour used to erase the previous sprite.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  game running; a render cycle starts only when high.
REQ-006 doneUpdate  input  1  one-cycle completion pulse from the enemy datapath.
REQ-007 enemy_x  input  8  enemy datapath X position, 0..159.
REQ-008 enemy_y  input  7  enemy datapath Y position, 0..119.
REQ-009 enemy_colour  input  3  enemy sprite colour.
REQ-010 UpdateEnemy  output  1  update request to the enemy datapath.
REQ-011 plot  output  1  VGA pixel write strobe.
REQ-012 vga_x  output  8  pixel X coordinate.
REQ-013 vga_y  output  7  pixel Y coordinate.
REQ-014 vga_colour  output  3  pixel colour.
REQ-015 frame_done  output  1  one-cycle pulse when a render cycle completes.

Function
REQ-016 FSM states SHALL be IDLE, REQ, ERASE, DRAW, DONE.
REQ-017 IDLE -> REQ when enable=1; otherwise stay in IDLE.
REQ-018 In REQ, UpdateEnemy SHALL be 1 and held until doneUpdate=1 is sampled; it SHALL be 0 in every other state.
REQ-019 On the edge sampling doneUpdate=1 in REQ: latch enemy_x, enemy_y and enemy_colour as new_x, new_y and new_col; next state ERASE, or DRAW if first_frame=1.
REQ-020 doneUpdate outside REQ SHALL be ignored.
REQ-021 ERASE SHALL scan old_x..old_x+SIZE-1 by old_y..old_y+SIZE-1, row-major (x fastest), one pixel per cycle, exactly SIZE*SIZE cycles, with vga_colour=BG_COLOUR; ERASE -> DRAW.
REQ-022 DRAW SHALL scan the same pattern at new_x/new_y with vga_colour=new_col, exactly SIZE*SIZE cycles; DRAW -> DONE.
REQ-023 DONE SHALL last one cycle with frame_done=1, copy new_x/new_y to old_x/old_y, clear first_frame, and go to IDLE.
REQ-024 vga_x/vga_y SHALL be registered outputs; vga_x=base_x+px truncated to 8 bits and vga_y=base_y+py truncated to 7 bits.
REQ-025 plot SHALL be 1 during every ERASE/DRAW scan cycle except when the pixel is off-screen (vga_x>159 or vga_y>119, including wrap from truncation); off-screen pixels still consume a cycle.
REQ-026 enable SHALL be sampled only in IDLE; dropping enable mid-cycle SHALL NOT abort the cycle.
REQ-027 Latency from leaving IDLE to frame_done, excluding REQ wait: 2*SIZE*SIZE+1 cycles, or SIZE*SIZE+1 on the first frame.

Reset
REQ-028 While reset=1: state=IDLE; UpdateEnemy, plot, frame_done, vga_x, vga_y, vga_colour, old_x, old_y, pixel counters=0; first_frame=1.
REQ-029 Reset asserted mid-ERASE/DRAW/REQ SHALL abort immediately; the next cycle after release SHALL skip ERASE.

Configuration
REQ-030 Macro ENEMY_RENDER_ERASE_EN: when defined, behaviour is as above; when undefined, the ERASE state SHALL NOT exist, REQ SHALL always go to DRAW, and latency SHALL be SIZE*SIZE+1 every frame.

Verification
REQ-031 Reset release, enable=1, doneUpdate after 3 cycles with enemy_x=150, enemy_y=110, colour=3'b100 -> no erase; 16 plot pulses covering x 150..153, y 110..113, colour 100; then frame_done.
REQ-032 Second frame with new x=149 -> 16 erase pixels at x 150..153 with colour 000, then 16 draw pixels at x 149..152; frame_done 33 cycles after the done sample.
REQ-033 enemy_x=158, enemy_y=118 -> plot=0 for x 160/161 and y 120/121; exactly 4 plots occur, and the scan still takes 16 cycles.
REQ-034 doneUpdate pulsed during DRAW -> ignored; UpdateEnemy stays 0 and no relatch occurs.
REQ-035 Reset pulsed at the 8th DRAW pixel -> all outputs 0 immediately; the next frame performs no erase.
REQ-036 With ENEMY_RENDER_ERASE_EN undefined, two frames -> no BG_COLOUR pixels are plotted, and each frame takes 17 cycles after the done sample.
